// File: rtl/div_seq_32.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle, with a signed
// fixup on completion and an immediate divide-by-zero result.
module div_seq_32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT         stateReg, stateNext;
  logic [CW-1:0] countReg, countNext;
  logic [W-1:0]  remReg, remNext;
  logic [W-1:0]  dvdReg, dvdNext;
  logic [W-1:0]  dvsReg, dvsNext;
  logic          negQReg, negQNext;
  logic          negRReg, negRNext;
  logic [W-1:0]  qNext, rNext;
  logic          dzNext;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic [W-1:0]  qMag, rMag;
  logic          xNeg, yNeg;

  assign busy = (stateReg != IDLE);
  assign done = (stateReg == DONE);

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    remNext   = remReg;
    dvdNext   = dvdReg;
    dvsNext   = dvsReg;
    negQNext  = negQReg;
    negRNext  = negRReg;
    qNext     = q;
    rNext     = r;
    dzNext    = dz;

    // Quotient bits shift into the low end of the dividend register as it empties.
    shifted = {remReg, dvdReg[W-1]};
    diff    = shifted - {1'b0, dvsReg};
    qMag    = {dvdReg[W-2:0], ~diff[W]};
    rMag    = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    xNeg    = signed_op & x[W-1];
    yNeg    = signed_op & y[W-1];

    case (stateReg)
      IDLE: begin
        if (start) begin
          if (y == '0) begin
            stateNext = DONE;
            qNext     = '1;
            rNext     = x;
            dzNext    = 1'b1;
          end else begin
            stateNext = RUN;
            dvdNext   = xNeg ? -x : x;
            dvsNext   = yNeg ? -y : y;
            remNext   = '0;
            countNext = '0;
            negQNext  = xNeg ^ yNeg;
            negRNext  = xNeg;
          end
        end
      end
      RUN: begin
        remNext   = rMag;
        dvdNext   = qMag;
        countNext = countReg + CW'(1);
        if (countReg == CW'(W - 1)) begin
          stateNext = DONE;
          qNext     = negQReg ? -qMag : qMag;
          rNext     = negRReg ? -rMag : rMag;
          dzNext    = 1'b0;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      countReg <= '0;
      remReg   <= '0;
      dvdReg   <= '0;
      dvsReg   <= '0;
      negQReg  <= 1'b0;
      negRReg  <= 1'b0;
      q        <= '0;
      r        <= '0;
      dz       <= 1'b0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      remReg   <= remNext;
      dvdReg   <= dvdNext;
      dvsReg   <= dvsNext;
      negQReg  <= negQNext;
      negRReg  <= negRNext;
      q        <= qNext;
      r        <= rNext;
      dz       <= dzNext;
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Directed and randomized checks of div_seq_32: latency, results, signed fixup,
// divide by zero, ignored starts, back-to-back throughput and mid-run reset.
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signedOp = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        busy, done, dz;
  logic [31:0] q, r;

  int total = 0;
  int bad = 0;

  div_seq_32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signedOp),
    .x(x), .y(y), .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with lat = cycles elapsed since the reference edge.
  task automatic waitDone(input int lat0, input int expLat, input string tag);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, expLat);
  endtask

  task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input string tag);
    @(negedge clk);
    signedOp = s; x = a; y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = $urandom; y = $urandom; signedOp = ~s;
    chk({tag, "_busy1"}, busy, 1'b1);
    waitDone(1, (b == 0) ? 1 : 33, tag);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_busyd"}, busy, 1'b1);
    chk({tag, "_id"}, q * b + r, a);
    $display("op %s s=%0d x=%h y=%h -> q=%h r=%h dz=%0d", tag, s, a, b, q, r, dz);
    @(negedge clk);
    chk({tag, "_done0"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        s, edz;
    longint      sa, sb;
    int          pulses;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", q, 32'h0);
    chk("rst_r", r, 32'h0);
    chk("rst_dz", dz, 1'b0);
    rst_n = 1'b1;

    runOp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u100_7");
    runOp(1'b1, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "s-7_2");
    runOp(1'b1, 32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0, "s7_-2");
    runOp(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, "umax_1");
    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, "sovf");
    runOp(1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, "u5_9");
    runOp(1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, "dz");
    runOp(1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, "u10_3");

    // Start pulse during RUN with different operands is ignored
    @(negedge clk);
    signedOp = 1'b0; x = 32'd100; y = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    x = 32'd50; y = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(6, 33, "ignore");
    chk("ignore_q", q, 32'd14);
    chk("ignore_r", r, 32'd2);
    $display("op ignore-start x=100 y=7 -> q=%h r=%h", q, r);
    @(negedge clk);

    // Start held high: start in the DONE cycle is not accepted
    @(negedge clk);
    signedOp = 1'b0; x = 32'd100; y = 32'd7; start = 1'b1;
    @(negedge clk);
    waitDone(1, 33, "b2b1");
    chk("b2b1_q", q, 32'd14);
    x = 32'd45; y = 32'd6;
    @(negedge clk);
    waitDone(1, 34, "b2b2");
    start = 1'b0;
    chk("b2b2_q", q, 32'd7);
    chk("b2b2_r", r, 32'd3);
    $display("op back-to-back -> q=%h r=%h", q, r);
    @(negedge clk);

    // Reset during RUN cycle 10
    @(negedge clk);
    signedOp = 1'b0; x = 32'd1000; y = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_q", q, 32'h0);
    chk("mrst_r", r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("mrst_nodone", pulses, 0);
    $display("op mid-run reset -> done pulses afterwards=%0d", pulses);

    // Randomized regression against the language's own division
    for (int i = 0; i < 200; i++) begin
      s = 1'(($urandom & 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(0, 15);
        2:       b = -$urandom_range(1, 8);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (b == 0) begin
        eq = '1; er = a; edz = 1'b1;
      end else if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eq = 32'(sa / sb);
        er = 32'(sa % sb);
        edz = 1'b0;
      end else begin
        eq = a / b;
        er = a % b;
        edz = 1'b0;
      end
      runOp(s, a, b, eq, er, edz, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
